lab4_cpu_ocimem_monitor: RTL and testbench

On-chip debug memory (OCI memory) monitor for the lab4 Nios II CPU, in the system clock domain. It sits directly downstream of the JTAG debug-module wrapper and consumes its `jdo` bus and the `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a` strobes. It executes host-issued word reads and writes into a single-port debug RAM, which is shared with a CPU-side slave port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper.

---
 rtl/lab4_cpu_ocimem_monitor.sv | 161 ++++++++++++++++
 tb/tb_lab4_cpu_ocimem_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_cpu_ocimem_monitor.sv
// JTAG-driven OCI debug-memory monitor sharing a single-port debug RAM with a CPU slave port.
// Optional LAB4_CPU_OCIMEM_ROM_PROTECT_EN makes the lower half of the RAM read-only.
module lab4_cpu_ocimem_monitor #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_writedata,
  input  logic [3:0]    cpu_byteenable,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR} state_t;

  state_t        state, state_next;
  logic [AW-1:0] mon_a_reg;
  logic [31:0]   wr_data;
  logic [31:0]   ram_q;
  logic          live;
  logic          cpu_rd_pending;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr;
  logic          ram_re, ram_we, cpu_rd_issue;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;

  logic is_idle, jtag_port, multi, err_set, err_clr;
  logic accept_a, accept_b, accept_n;
  logic jtag_wr_blocked, cpu_wr_blocked;

  wire unused_jdo = &{1'b0, jdo[37:36], jdo[33:32]};

`ifdef LAB4_CPU_OCIMEM_ROM_PROTECT_EN
  assign jtag_wr_blocked = ~mon_a_reg[AW-1];
  assign cpu_wr_blocked  = ~cpu_address[AW-1];
`else
  assign jtag_wr_blocked = 1'b0;
  assign cpu_wr_blocked  = 1'b0;
`endif

  assign is_idle   = (state == IDLE);
  assign jtag_port = (state == RD_ISSUE) || (state == WR);

  // Strobe priority a > b > no_action_a; strobes outside IDLE are dropped
  assign accept_a = is_idle & take_action_ocimem_a;
  assign accept_b = is_idle & ~take_action_ocimem_a & take_action_ocimem_b;
  assign accept_n = is_idle & ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
  assign multi    = (take_action_ocimem_a & take_action_ocimem_b) |
                    (take_action_ocimem_a & take_no_action_ocimem_a) |
                    (take_action_ocimem_b & take_no_action_ocimem_a);
  assign err_set  = (~is_idle & (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)) |
                    multi | ((state == WR) & jtag_wr_blocked);
  assign err_clr  = accept_a & jdo[35];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_a && jdo[34]) state_next = RD_ISSUE;
        else if (accept_b)       state_next = WR;
        else if (accept_n)       state_next = RD_ISSUE;
      end
      RD_ISSUE: state_next = RD_CAP;
      RD_CAP:   state_next = IDLE;
      WR:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The JTAG FSM owns the RAM port in RD_ISSUE/WR; the CPU gets every other cycle
  always_comb begin
    ram_addr     = mon_a_reg;
    ram_re       = 1'b0;
    ram_we       = 1'b0;
    ram_be       = 4'hF;
    ram_wdata    = wr_data;
    cpu_rd_issue = 1'b0;
    if (state == RD_ISSUE) begin
      ram_re = 1'b1;
    end else if (state == WR) begin
      ram_we = ~jtag_wr_blocked;
    end else if (live) begin
      if (cpu_write) begin
        ram_addr  = cpu_address;
        ram_we    = ~cpu_wr_blocked;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
      end else if (cpu_read && !cpu_rd_pending) begin
        ram_addr     = cpu_address;
        ram_re       = 1'b1;
        cpu_rd_issue = 1'b1;
      end
    end
  end

  always_comb begin
    cpu_waitrequest = 1'b1;
    if (live) begin
      if (cpu_write)     cpu_waitrequest = jtag_port;
      else if (cpu_read) cpu_waitrequest = ~cpu_rd_pending;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mon_a_reg      <= '0;
      MonDReg        <= '0;
      wr_data        <= '0;
      monitor_ready  <= 1'b0;
      monitor_error  <= 1'b0;
      live           <= 1'b0;
      cpu_rd_pending <= 1'b0;
    end else begin
      state          <= state_next;
      monitor_ready  <= (state_next == IDLE);
      monitor_error  <= err_set | (monitor_error & ~err_clr);
      live           <= 1'b1;
      cpu_rd_pending <= cpu_rd_issue;
      if (accept_a) mon_a_reg <= jdo[AW+1:2];
      if (accept_b) wr_data <= jdo[31:0];
      if (state == RD_CAP) begin
        MonDReg   <= ram_q;
        mon_a_reg <= mon_a_reg + 1'b1;
      end
      if (state == WR) begin
        MonDReg   <= wr_data;
        mon_a_reg <= mon_a_reg + 1'b1;
      end
    end
  end

  // RAM contents survive reset; writes are gated by state/live, which reset clears at once
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ram_q <= '0;
    else if (ram_re) ram_q <= ram[ram_addr];
  end

  assign cpu_readdata = ram_q;

endmodule

// File: tb/tb_lab4_cpu_ocimem_monitor.sv
// Directed self-checking bench for lab4_cpu_ocimem_monitor (AW=8).
module tb_lab4_cpu_ocimem_monitor;

  localparam int AW = 8;
  localparam int K_A = 0, K_B = 1, K_N = 2;
`ifdef LAB4_CPU_OCIMEM_ROM_PROTECT_EN
  localparam logic [7:0] BASE = 8'h80;
`else
  localparam logic [7:0] BASE = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [AW-1:0] cpu_address;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_writedata;
  logic [3:0]    cpu_byteenable;
  logic [31:0]   cpu_readdata;
  logic          cpu_waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  int total = 0;
  int bad = 0;

  lab4_cpu_ocimem_monitor #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] make_cmd(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] v;
    v = '0;
    v[AW+1:2] = addr;
    v[34] = rd;
    v[35] = clr;
    return v;
  endfunction

  // Pulses one strobe for a single cycle; returns just after the sampling edge
  task automatic applyStimulus(input int kind, input logic [37:0] data);
    jdo = data;
    take_action_ocimem_a    = (kind == K_A);
    take_action_ocimem_b    = (kind == K_B);
    take_no_action_ocimem_a = (kind == K_N);
    step(1);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;

    step(3);
    checkOutput("rst_mondreg", MonDReg, 32'h0);
    checkOutput("rst_ready", {31'b0, monitor_ready}, 32'h0);
    checkOutput("rst_error", {31'b0, monitor_error}, 32'h0);
    checkOutput("rst_readdata", cpu_readdata, 32'h0);
    checkOutput("rst_waitreq", {31'b0, cpu_waitrequest}, 32'h1);
    reset_n = 1'b1;
    step(1);
    checkOutput("ready_after_rst", {31'b0, monitor_ready}, 32'h1);

    // Load address, stream two writes, then read them back
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b0, 1'b0));
    checkOutput("load_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("load_areg", {24'b0, dut.mon_a_reg}, {24'b0, BASE + 8'h10});
    applyStimulus(K_B, {6'b0, 32'hDEADBEEF});
    checkOutput("wr_busy", {31'b0, monitor_ready}, 32'h0);
    step(1);
    checkOutput("wr1_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("wr1_mondreg", MonDReg, 32'hDEADBEEF);
    applyStimulus(K_B, {6'b0, 32'h12345678});
    step(1);
    checkOutput("wr2_mondreg", MonDReg, 32'h12345678);
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b1, 1'b0));
    checkOutput("rd_n0_ready", {31'b0, monitor_ready}, 32'h0);
    step(1);
    checkOutput("rd_n1_ready", {31'b0, monitor_ready}, 32'h0);
    step(1);
    checkOutput("rd_n2_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("rd1_mondreg", MonDReg, 32'hDEADBEEF);
    applyStimulus(K_N, '0);
    step(2);
    checkOutput("rd2_mondreg", MonDReg, 32'h12345678);
    checkOutput("rd2_areg", {24'b0, dut.mon_a_reg}, {24'b0, BASE + 8'h12});

    // Pointer wrap from the top word back to word 0
`ifndef LAB4_CPU_OCIMEM_ROM_PROTECT_EN
    applyStimulus(K_A, make_cmd(8'h00, 1'b0, 1'b0));
    applyStimulus(K_B, {6'b0, 32'h0BADC0DE});
    step(1);
`endif
    applyStimulus(K_A, make_cmd(8'hFF, 1'b0, 1'b1));
    applyStimulus(K_B, {6'b0, 32'hA5A5A5A5});
    step(1);
    checkOutput("wrap_areg", {24'b0, dut.mon_a_reg}, 32'h0);
    checkOutput("wrap_error", {31'b0, monitor_error}, 32'h0);
    applyStimulus(K_N, '0);
    step(2);
`ifndef LAB4_CPU_OCIMEM_ROM_PROTECT_EN
    checkOutput("wrap_rd_word0", MonDReg, 32'h0BADC0DE);
`endif
    checkOutput("wrap_rd_areg", {24'b0, dut.mon_a_reg}, 32'h1);

    // Busy strobe during a read is dropped and flags an error
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b1, 1'b0));
    applyStimulus(K_N, '0);
    checkOutput("busy_error", {31'b0, monitor_error}, 32'h1);
    step(2);
    checkOutput("busy_mondreg", MonDReg, 32'hDEADBEEF);
    checkOutput("busy_areg", {24'b0, dut.mon_a_reg}, {24'b0, BASE + 8'h11});
    checkOutput("busy_ready", {31'b0, monitor_ready}, 32'h1);
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b0, 1'b1));
    checkOutput("err_cleared", {31'b0, monitor_error}, 32'h0);

    // Simultaneous a and b: command wins, b dropped, error set
    jdo = make_cmd(BASE + 8'h40, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    step(1);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    checkOutput("multi_error", {31'b0, monitor_error}, 32'h1);
    checkOutput("multi_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("multi_areg", {24'b0, dut.mon_a_reg}, {24'b0, BASE + 8'h40});
    applyStimulus(K_A, make_cmd(BASE + 8'h20, 1'b0, 1'b1));
    applyStimulus(K_B, {6'b0, 32'h11223344});
    step(1);

    // CPU read colliding with WR: stall for the WR cycle plus read latency
    applyStimulus(K_A, make_cmd(BASE + 8'h30, 1'b0, 1'b0));
    applyStimulus(K_B, {6'b0, 32'h55667788});
    cpu_address = BASE + 8'h20;
    cpu_read = 1'b1;
    #1;
    checkOutput("arb_wait_wr", {31'b0, cpu_waitrequest}, 32'h1);
    step(1);
    checkOutput("arb_wait_grant", {31'b0, cpu_waitrequest}, 32'h1);
    step(1);
    checkOutput("arb_wait_done", {31'b0, cpu_waitrequest}, 32'h0);
    checkOutput("arb_rdata", cpu_readdata, 32'h11223344);
    cpu_read = 1'b0;

    // CPU write with low half-word lanes only
    cpu_write = 1'b1;
    cpu_writedata = 32'hAABBCCDD;
    cpu_byteenable = 4'b0011;
    #1;
    checkOutput("cpu_wr_wait", {31'b0, cpu_waitrequest}, 32'h0);
    step(1);
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    #1;
    checkOutput("cpu_rd_wait", {31'b0, cpu_waitrequest}, 32'h1);
    step(1);
    checkOutput("cpu_rd_wait2", {31'b0, cpu_waitrequest}, 32'h0);
    checkOutput("cpu_be_rdata", cpu_readdata, 32'h1122CCDD);
    cpu_read = 1'b0;

    // Reset while in RD_ISSUE
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b1, 1'b0));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_mondreg", MonDReg, 32'h0);
    checkOutput("mid_rst_ready", {31'b0, monitor_ready}, 32'h0);
    checkOutput("mid_rst_error", {31'b0, monitor_error}, 32'h0);
    checkOutput("mid_rst_rdata", cpu_readdata, 32'h0);
    checkOutput("mid_rst_waitreq", {31'b0, cpu_waitrequest}, 32'h1);
    checkOutput("mid_rst_areg", {24'b0, dut.mon_a_reg}, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    checkOutput("mid_rst_ready_back", {31'b0, monitor_ready}, 32'h1);
    applyStimulus(K_A, make_cmd(BASE + 8'h10, 1'b1, 1'b0));
    step(2);
    checkOutput("ram_kept_10", MonDReg, 32'hDEADBEEF);
    applyStimulus(K_N, '0);
    step(2);
    checkOutput("ram_kept_11", MonDReg, 32'h12345678);

`ifdef LAB4_CPU_OCIMEM_ROM_PROTECT_EN
    applyStimulus(K_A, make_cmd(8'h05, 1'b0, 1'b1));
    applyStimulus(K_B, {6'b0, 32'h77777777});
    step(1);
    checkOutput("rom_error", {31'b0, monitor_error}, 32'h1);
    checkOutput("rom_areg", {24'b0, dut.mon_a_reg}, 32'h6);
    applyStimulus(K_A, make_cmd(8'h05, 1'b1, 1'b1));
    step(2);
    checkOutput("rom_unchanged", {31'b0, (MonDReg != 32'h77777777)}, 32'h1);
    applyStimulus(K_A, make_cmd(8'h80, 1'b0, 1'b1));
    applyStimulus(K_B, {6'b0, 32'h88888888});
    step(1);
    checkOutput("upper_wr_error", {31'b0, monitor_error}, 32'h0);
    applyStimulus(K_A, make_cmd(8'h80, 1'b1, 1'b0));
    step(2);
    checkOutput("upper_wr_data", MonDReg, 32'h88888888);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
